// File: rtl/fp_mul_pipe_44_pkg.sv
// Shared definitions for the parametrised floating-point multiplier:
// operand classes, flag bit positions and the canonical quiet NaN.
package fp_mul_pkg_44;

   typedef enum logic [2:0] {
      ZERO,
      NORM,
      INF,
      QNAN,
      SNAN
   } fp_class_e;

   // Bit positions inside the 4-bit flags vector {NV, OF, UF, NX}
   localparam int NV = 3;
   localparam int OF = 2;
   localparam int UF = 1;
   localparam int NX = 0;

   // Widest supported format: 1 + 11 + 23
   localparam int MAX_W = 35;

   // Canonical qNaN: sign 0, exponent all ones, only the fraction MSB set
   function automatic logic [MAX_W-1:0] canon_qnan(input int exp_w, input int man_w);
      logic [MAX_W-1:0] q;
      q = ((MAX_W'(1) << exp_w) - MAX_W'(1)) << man_w;
      q = q | (MAX_W'(1) << (man_w - 1));
      return q;
   endfunction

endpackage

// File: rtl/fp_mul_pipe_44_if.sv
// Operand/result streaming interface of the floating-point multiplier.
// master = operand source and result consumer, slave = multiplier.
interface fp_mul_pipe_44_if #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 7
);
   localparam int W = 1 + EXP_W + MAN_W;

   logic         in_valid_44;
   logic         in_ready_44;
   logic [W-1:0] a_44;
   logic [W-1:0] b_44;
   logic         out_valid_44;
   logic         out_ready_44;
   logic [W-1:0] result_44;
   logic [3:0]   flags_44;

   modport master (
      output in_valid_44, a_44, b_44, out_ready_44,
      input  in_ready_44, out_valid_44, result_44, flags_44
   );

   modport slave (
      input  in_valid_44, a_44, b_44, out_ready_44,
      output in_ready_44, out_valid_44, result_44, flags_44
   );

endinterface

// File: rtl/fp_mul_pipe_44_unpack.sv
// Combinational field extraction and classification of one operand.
// Denormals are treated as zero (sign kept); the significand of a zero is 0.
module fp_unpack_44
   import fp_mul_pkg_44::*;
#(
   parameter  int EXP_W = 8,
   parameter  int MAN_W = 7,
   localparam int W     = 1 + EXP_W + MAN_W
) (
   input  logic [W-1:0]     op,
   output logic             sign,
   output logic [EXP_W-1:0] exp_f,
   output logic [MAN_W:0]   sig,
   output fp_class_e        cls
);

   logic [MAN_W-1:0] frac;

   assign sign  = op[W-1];
   assign exp_f = op[W-2:MAN_W];
   assign frac  = op[MAN_W-1:0];
   assign sig   = (exp_f == '0) ? '0 : {1'b1, frac};

   // Classify the operand from its exponent and fraction fields
   always_comb begin
      // NOTE: default assigned first so every path drives cls and no latch is inferred.
      cls = NORM;
      if (exp_f == '0) begin
         cls = ZERO;
      end else if (&exp_f) begin
         if (frac == '0)
            cls = INF;
         else if (frac[MAN_W-1])
            cls = QNAN;
         else
            cls = SNAN;
      end
   end

endmodule

// File: rtl/fp_mul_pipe_44.sv
// Parametrised floating-point multiplier, round-to-nearest-even, flush-to-zero.
// Operand latch followed by three stages (multiply, normalise, round/pack);
// every stage advances together when the output is free or being drained.
// Optional IEEE flags {NV, OF, UF, NX} are built when FP_MUL_FLAGS_EN is defined;
// otherwise flags_44 is tied to zero.
module fp_mul_pipe_44
   import fp_mul_pkg_44::*;
#(
   parameter int EXP_W = 8,
   parameter int MAN_W = 7
) (
   input logic          clk_44,
   input logic          rst_n_44,
   fp_mul_pipe_44_if.slave bus_44
);

   localparam int W    = 1 + EXP_W + MAN_W;
   localparam int BIAS = (1 << (EXP_W - 1)) - 1;
   localparam int PW   = 2 * MAN_W + 2;
   localparam int EW   = EXP_W + 2;

   localparam logic [MAX_W-1:0] QNAN_FULL = canon_qnan(EXP_W, MAN_W);
   localparam logic [W-1:0]     QNAN_VAL  = QNAN_FULL[W-1:0];
   localparam logic [EW-1:0]    EXP_INF   = EW'((1 << EXP_W) - 1);
   localparam logic [EW-1:0]    EXP_ONE   = EW'(1);

   logic adv;
   assign adv                = !bus_44.out_valid_44 || bus_44.out_ready_44;
   assign bus_44.in_ready_44 = adv;

   // Pipeline valid bits and registers
   logic             op_valid, s1_valid, s2_valid, out_valid;
   logic [W-1:0]     op_a, op_b;
   logic             s1_sign, s1_special;
   logic [EW-1:0]    s1_exp;
   logic [PW-1:0]    s1_prod;
   logic [W-1:0]     s1_spec_res;
   logic             s2_sign, s2_special, s2_guard, s2_sticky;
   logic [EW-1:0]    s2_exp;
   logic [MAN_W-1:0] s2_frac;
   logic [W-1:0]     s2_spec_res;
   logic [W-1:0]     result_q;

   // S1: unpack, classify, multiply
   logic             sign_a, sign_b;
   logic [EXP_W-1:0] exp_a, exp_b;
   logic [MAN_W:0]   sig_a, sig_b;
   fp_class_e        cls_a, cls_b;

   fp_unpack_44 #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_a (
      .op(op_a), .sign(sign_a), .exp_f(exp_a), .sig(sig_a), .cls(cls_a)
   );
   fp_unpack_44 #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_b (
      .op(op_b), .sign(sign_b), .exp_f(exp_b), .sig(sig_b), .cls(cls_b)
   );

   logic          sign_d, any_snan, any_nan, any_inf, any_zero, inv_op, special_d;
   logic [W-1:0]  spec_res_d;
   logic [PW-1:0] prod_d;
   logic [EW-1:0] exp_d;

   // Special-value resolution in priority order: NaN / Inf*0, Inf, zero
   always_comb begin
      sign_d     = sign_a ^ sign_b;
      any_snan   = (cls_a == SNAN) || (cls_b == SNAN);
      any_nan    = any_snan || (cls_a == QNAN) || (cls_b == QNAN);
      any_inf    = (cls_a == INF) || (cls_b == INF);
      any_zero   = (cls_a == ZERO) || (cls_b == ZERO);
      inv_op     = any_inf && any_zero;
      special_d  = any_nan || any_inf || any_zero;
      spec_res_d = QNAN_VAL;
      if (any_nan || inv_op)
         spec_res_d = QNAN_VAL;
      else if (any_inf)
         spec_res_d = {sign_d, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      else if (any_zero)
         spec_res_d = {sign_d, {(W-1){1'b0}}};
   end

   assign prod_d = PW'(sig_a) * PW'(sig_b);
   assign exp_d  = EW'(exp_a) + EW'(exp_b) - EW'(BIAS);

   // S2: normalise the product to 1.f and split off guard and sticky
   logic [EW-1:0]    n_exp;
   logic [MAN_W-1:0] n_frac;
   logic             n_guard, n_sticky;

   // Select the kept field depending on whether the product reached [2,4)
   always_comb begin
      n_exp    = s1_exp;
      n_frac   = s1_prod[PW-3:MAN_W];
      n_guard  = s1_prod[MAN_W-1];
      n_sticky = |s1_prod[MAN_W-2:0];
      if (s1_prod[PW-1]) begin
         n_exp    = s1_exp + EXP_ONE;
         n_frac   = s1_prod[PW-2:MAN_W+1];
         n_guard  = s1_prod[MAN_W];
         n_sticky = |s1_prod[MAN_W-1:0];
      end
   end

   // S3: round to nearest even and pack
   logic             rnd_up, rnd_carry, ovf, unf;
   logic [EW-1:0]    r_exp;
   logic [MAN_W-1:0] r_frac;
   logic [W-1:0]     res_d;

   // Round, detect overflow/underflow after rounding, then choose the result
   always_comb begin
      rnd_up    = s2_guard && (s2_sticky || s2_frac[0]);
      rnd_carry = rnd_up && (&s2_frac);
      r_frac    = s2_frac + MAN_W'(rnd_up);
      r_exp     = rnd_carry ? (s2_exp + EXP_ONE) : s2_exp;
      ovf       = $signed(r_exp) >= $signed(EXP_INF);
      unf       = $signed(r_exp) < $signed(EXP_ONE);
      res_d     = {s2_sign, r_exp[EXP_W-1:0], r_frac};
      if (s2_special)
         res_d = s2_spec_res;
      else if (ovf)
         res_d = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      else if (unf)
         res_d = {s2_sign, {(W-1){1'b0}}};
   end

   // Valid chain and output register; reset discards everything in flight
   always_ff @(posedge clk_44 or negedge rst_n_44) begin
      // NOTE: sequential state uses non-blocking assignments so all stages sample pre-edge values.
      if (!rst_n_44) begin
         op_valid  <= 1'b0;
         s1_valid  <= 1'b0;
         s2_valid  <= 1'b0;
         out_valid <= 1'b0;
         result_q  <= '0;
      end else if (adv) begin
         op_valid  <= bus_44.in_valid_44;
         s1_valid  <= op_valid;
         s2_valid  <= s1_valid;
         out_valid <= s2_valid;
         if (s2_valid)
            result_q <= res_d;
      end
   end

   // Datapath stage registers, qualified by the valid chain
   always_ff @(posedge clk_44) begin
      // NOTE: datapath registers are not reset; the valid bits alone decide what is meaningful.
      if (adv) begin
         op_a        <= bus_44.a_44;
         op_b        <= bus_44.b_44;
         s1_sign     <= sign_d;
         s1_special  <= special_d;
         s1_exp      <= exp_d;
         s1_prod     <= prod_d;
         s1_spec_res <= spec_res_d;
         s2_sign     <= s1_sign;
         s2_special  <= s1_special;
         s2_exp      <= n_exp;
         s2_frac     <= n_frac;
         s2_guard    <= n_guard;
         s2_sticky   <= n_sticky;
         s2_spec_res <= s1_spec_res;
      end
   end

   assign bus_44.out_valid_44 = out_valid;
   assign bus_44.result_44    = result_q;

`ifdef FP_MUL_FLAGS_EN
   logic       nv_d, s1_nv, s2_nv;
   logic [3:0] flags_d, flags_q;

   assign nv_d = any_snan || inv_op;

   // Exception flags for the result leaving S3
   always_comb begin
      flags_d = '0;
      if (s2_special) begin
         flags_d[NV] = s2_nv;
      end else begin
         flags_d[OF] = ovf;
         flags_d[UF] = unf;
         flags_d[NX] = ovf || unf || s2_guard || s2_sticky;
      end
   end

   // Carry the invalid-operation indication alongside the datapath
   always_ff @(posedge clk_44) begin
      if (adv) begin
         s1_nv <= nv_d;
         s2_nv <= s1_nv;
      end
   end

   // Output flags register, loaded together with the result
   always_ff @(posedge clk_44 or negedge rst_n_44) begin
      if (!rst_n_44)
         flags_q <= '0;
      else if (adv && s2_valid)
         flags_q <= flags_d;
   end

   assign bus_44.flags_44 = flags_q;
`else
   assign bus_44.flags_44 = 4'b0000;
`endif

endmodule
